// File: rtl/stream_cmd_sequencer.sv
// Autonomous command master for the streamer control interface: queues transfer
// descriptors and runs each through issue / ack / completion / release on Command0.
module stream_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int ACK_TIMEOUT    = 64,
    parameter int XFER_TIMEOUT   = 65535,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [7:0]  desc_op,
    input  logic [2:0]  desc_proc,
    input  logic        desc_all,
    input  logic [15:0] desc_addr,
    output logic [31:0] Command0,
    input  logic [31:0] Status0,
    input  logic        clr_err,
    output logic        busy,
    output logic        done_pulse,
    output logic        illegal_pulse,
    output logic        timeout_err,
    output logic [15:0] xfer_count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TMAX = (XFER_TIMEOUT > ACK_TIMEOUT) ?
                          ((XFER_TIMEOUT > RELEASE_CYCLES) ? XFER_TIMEOUT : RELEASE_CYCLES) :
                          ((ACK_TIMEOUT > RELEASE_CYCLES) ? ACK_TIMEOUT : RELEASE_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RELEASE,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   cmd_q, cmd_d;
    logic          sel_q, sel_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          done_q, done_d;
    logic          illegal_q, illegal_d;
    logic          err_q, err_d;
    logic [15:0]   count_q, count_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    logic [31:0]   cmd_mem [FIFO_DEPTH];
    logic          sel_mem [FIFO_DEPTH];

    logic          full, empty, op_legal, push, pop, done_bit;
    logic [TW-1:0] timer_inc;
    logic          unused_status;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign op_legal = (desc_op >= 8'd1) && (desc_op <= 8'd4);
    assign push     = desc_valid && !full && op_legal;
    assign done_bit = sel_q ? Status0[16] : Status0[0];
    assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + TW'(1);
    assign unused_status = ^{Status0[31:17], Status0[15:1]};

    // NOTE: descriptor storage has no reset; only the pointers define what is valid,
    // so clearing the array would cost reset fan-out for no functional gain.
    always_ff @(posedge ACLK) begin
        if (push) begin
            cmd_mem[wr_ptr_q[AW-1:0]] <= {desc_op, 1'b0, desc_proc, 3'b000, desc_all, desc_addr};
            sel_mem[wr_ptr_q[AW-1:0]] <= (desc_op == 8'd2) || (desc_op == 8'd4);
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cmd_d     = cmd_q;
        sel_d     = sel_q;
        timer_d   = timer_q;
        done_d    = 1'b0;
        illegal_d = desc_valid && !full && !op_legal;
        err_d     = err_q && !clr_err;
        count_d   = count_q;
        pop       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    cmd_d   = cmd_mem[rd_ptr_q[AW-1:0]];
                    sel_d   = sel_mem[rd_ptr_q[AW-1:0]];
                    timer_d = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!done_bit) begin
                    timer_d = '0;
                    state_d = S_BUSY;
                end else if (timer_q >= TW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cmd_d   = '0;
                    state_d = S_HALT;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_BUSY: begin
                if (done_bit) begin
                    cmd_d   = '0;
                    done_d  = 1'b1;
                    count_d = count_q + 16'd1;
                    timer_d = '0;
                    state_d = S_RELEASE;
                end else if (timer_q >= TW'(XFER_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cmd_d   = '0;
                    state_d = S_HALT;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_RELEASE: begin
                cmd_d = '0;
                if (timer_q >= TW'(RELEASE_CYCLES - 1)) state_d = S_IDLE;
                else                                    timer_d = timer_inc;
            end
            S_HALT: begin
                cmd_d = '0;
                if (clr_err) state_d = S_IDLE;
            end
            default: begin
                cmd_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            sel_q     <= 1'b0;
            timer_q   <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            sel_q     <= sel_d;
            timer_q   <= timer_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    assign desc_ready    = !full;
    assign Command0      = cmd_q;
    assign done_pulse    = done_q;
    assign illegal_pulse = illegal_q;
    assign timeout_err   = err_q;
    assign xfer_count    = count_q;
    assign busy          = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_stream_cmd_sequencer.sv
// Scoreboard bench for stream_cmd_sequencer: a behavioural streamer drives Status0,
// stimulus pushes expected commands, and a monitor checks everything the DUT emits.
module tb_stream_cmd_sequencer;

    localparam int FD = 4;
    localparam int AT = 64;
    localparam int XT = 300;
    localparam int RC = 2;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        desc_valid;
    logic        desc_ready;
    logic [7:0]  desc_op;
    logic [2:0]  desc_proc;
    logic        desc_all;
    logic [15:0] desc_addr;
    logic [31:0] Command0;
    logic [31:0] Status0;
    logic        clr_err;
    logic        busy;
    logic        done_pulse;
    logic        illegal_pulse;
    logic        timeout_err;
    logic [15:0] xfer_count;

    stream_cmd_sequencer #(
        .FIFO_DEPTH(FD), .ACK_TIMEOUT(AT), .XFER_TIMEOUT(XT), .RELEASE_CYCLES(RC)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_op(desc_op), .desc_proc(desc_proc), .desc_all(desc_all), .desc_addr(desc_addr),
        .Command0(Command0), .Status0(Status0), .clr_err(clr_err),
        .busy(busy), .done_pulse(done_pulse), .illegal_pulse(illegal_pulse),
        .timeout_err(timeout_err), .xfer_count(xfer_count)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0] exp_cmd_q [$];
    int          exp_ill_q [$];

    // streamer model controls and observations
    bit stall_ack   = 0;
    bit never_raise = 0;
    bit noise       = 0;
    bit rand_timing = 0;
    int ack_delay   = 1;
    int xfer_len    = 10;
    int st_phase    = 0;
    int raise_cyc   = -10;
    int last_drop_cyc  = 0;
    int last_issue_cyc = 0;
    int exp_done    = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ge(string name, int act, int min);
        n_vec++;
        if (act < min) begin
            n_fail++;
            $display("FAIL %s: got %0d expected at least %0d (cycle %0d)", name, act, min, cyc);
        end
    endtask

    function automatic logic [31:0] cmd_of(logic [7:0] op, logic [2:0] p, logic a, logic [15:0] ad);
        return (32'(op) << 24) | (32'(p) << 20) | (32'(a) << 16) | 32'(ad);
    endfunction

    // Streamer: acknowledges a new command by dropping its done bit, completes by raising it.
    initial begin
        logic b0, b16, st_rd;
        logic [31:0] st_prev;
        int st_cnt;
        b0 = 1'b1; b16 = 1'b1; st_rd = 1'b0; st_prev = '0; st_cnt = 0;
        Status0 = 32'h0001_0001;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                st_phase = 0; b0 = 1'b1; b16 = 1'b1; exp_done = 0; st_prev = '0;
            end else begin
                if (Command0 != 0 && st_prev == 0) begin
                    st_rd    = (Command0[31:24] == 8'd2) || (Command0[31:24] == 8'd4);
                    st_phase = 1;
                    st_cnt   = rand_timing ? int'($urandom_range(1, 3)) : ack_delay;
                    b0 = 1'b1; b16 = 1'b1;
                end else if (Command0 == 0) begin
                    st_phase = 0; b0 = 1'b1; b16 = 1'b1;
                end else if (st_phase == 1 && !stall_ack) begin
                    st_cnt--;
                    if (st_cnt <= 0) begin
                        if (st_rd) b16 = 1'b0; else b0 = 1'b0;
                        last_drop_cyc = cyc;
                        st_phase = 2;
                        st_cnt   = rand_timing ? int'($urandom_range(1, 20)) : xfer_len;
                    end
                end else if (st_phase == 2 && !never_raise) begin
                    st_cnt--;
                    if (st_cnt <= 0) begin
                        if (st_rd) b16 = 1'b1; else b0 = 1'b1;
                        raise_cyc = cyc;
                        exp_done++;
                        st_phase = 0;
                    end
                end
                st_prev = Command0;
                if (noise && st_phase != 0) begin
                    if (st_rd) b0 = 1'($urandom_range(0, 1));
                    else       b16 = 1'($urandom_range(0, 1));
                end
            end
            Status0 = {(noise ? 15'($urandom) : 15'd0), b16, (noise ? 15'($urandom) : 15'd0), b0};
        end
    end

    // Monitor: pops the scoreboard whenever the DUT issues a command or pulses an output.
    initial begin
        logic [31:0] mon_prev;
        int  zero_run;
        bit  had_done, prev_done;
        mon_prev = '0; zero_run = 0; had_done = 0; prev_done = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                mon_prev = '0; zero_run = 0; had_done = 0; prev_done = 0;
            end else begin
                if (Command0 != 0 && mon_prev == 0) begin
                    if (exp_cmd_q.size() == 0) check("cmd_unexpected", Command0, 32'h0);
                    else                       check("cmd_word", Command0, exp_cmd_q.pop_front());
                    if (had_done) check_ge("release_gap", zero_run, RC + 1);
                    had_done = 0;
                    last_issue_cyc = cyc;
                end
                zero_run = (Command0 == 0) ? zero_run + 1 : 0;
                if (done_pulse) begin
                    check("done_timing", cyc, raise_cyc + 1);
                    check("done_count", 32'(xfer_count), 32'(16'(exp_done)));
                    check("done_cmd_zero", Command0, 32'h0);
                    check("done_width", 32'(prev_done), 32'h0);
                    had_done = 1;
                end
                prev_done = done_pulse;
                if (illegal_pulse) begin
                    if (exp_ill_q.size() == 0) check("illegal_unexpected", 32'h1, 32'h0);
                    else                       check("illegal_timing", cyc, exp_ill_q.pop_front());
                end else if (exp_ill_q.size() > 0 && exp_ill_q[0] < cyc) begin
                    check("illegal_missing", 32'h0, 32'h1);
                    void'(exp_ill_q.pop_front());
                end
                mon_prev = Command0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the handshake with desc_valid still high.
    task automatic push_desc(logic [7:0] op, logic [2:0] p, logic a, logic [15:0] ad,
                             logic [31:0] exp_word);
        int waited;
        desc_valid = 1'b1; desc_op = op; desc_proc = p; desc_all = a; desc_addr = ad;
        waited = 0;
        while (!desc_ready && waited < 2000) begin
            @(negedge ACLK);
            waited++;
        end
        if (!desc_ready) begin
            check("push_ready_timeout", 32'h0, 32'h1);
        end else begin
            if ((op >= 8'd1) && (op <= 8'd4)) exp_cmd_q.push_back(exp_word);
            else                              exp_ill_q.push_back(cyc + 1);
        end
        @(negedge ACLK);
    endtask

    task automatic wait_drain(string name);
        int n;
        n = 0;
        while (!(busy == 1'b0 && exp_cmd_q.size() == 0 && exp_ill_q.size() == 0 && st_phase == 0)
               && n < 4000) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 4000) check({name, "_drain_timeout"}, 32'h0, 32'h1);
        repeat (2) @(negedge ACLK);
        check({name, "_count"}, 32'(xfer_count), 32'(16'(exp_done)));
        check({name, "_ready"}, 32'(desc_ready), 32'h1);
    endtask

    task automatic wait_timeout(int bound);
        int n;
        n = 0;
        while (!timeout_err && n < bound) begin
            @(negedge ACLK);
            n++;
        end
        if (!timeout_err) check("timeout_never_seen", 32'h0, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETN = 1'b0; desc_valid = 1'b0; desc_op = '0; desc_proc = '0;
        desc_all = 1'b0; desc_addr = '0; clr_err = 1'b0;
        #27 ARESETN = 1'b1;
        @(negedge ACLK);
        check("rst_cmd", Command0, 32'h0);
        check("rst_ready", 32'(desc_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_count", 32'(xfer_count), 32'h0);
        check("rst_err", 32'(timeout_err), 32'h0);
        check("rst_pulses", {30'h0, done_pulse, illegal_pulse}, 32'h0);

        // single write transfer
        ack_delay = 1; xfer_len = 10;
        push_desc(8'd1, 3'd2, 1'b0, 16'h0100, 32'h0120_0100);
        desc_valid = 1'b0;
        wait_drain("t1");
        check("t1_count_abs", 32'(xfer_count), 32'd1);

        // read-all-banks broadcast, completion keyed on bit16 while bit0 toggles
        noise = 1;
        push_desc(8'd4, 3'd0, 1'b1, 16'h0000, 32'h0401_0000);
        desc_valid = 1'b0;
        wait_drain("t2");
        noise = 0;

        // five back-to-back with a stalled streamer: one issues, four fill the queue
        stall_ack = 1;
        push_desc(8'd1, 3'd1, 1'b0, 16'h1111, cmd_of(8'd1, 3'd1, 1'b0, 16'h1111));
        push_desc(8'd2, 3'd3, 1'b1, 16'h2222, cmd_of(8'd2, 3'd3, 1'b1, 16'h2222));
        push_desc(8'd3, 3'd5, 1'b0, 16'h3333, cmd_of(8'd3, 3'd5, 1'b0, 16'h3333));
        push_desc(8'd4, 3'd7, 1'b1, 16'h4444, cmd_of(8'd4, 3'd7, 1'b1, 16'h4444));
        push_desc(8'd1, 3'd6, 1'b1, 16'hABCD, cmd_of(8'd1, 3'd6, 1'b1, 16'hABCD));
        desc_op = 8'd2;
        check("t3_full_ready", 32'(desc_ready), 32'h0);
        desc_valid = 1'b0;
        repeat (20) @(negedge ACLK);
        stall_ack = 0;
        wait_drain("t3");
        check("t3_count_abs", 32'(xfer_count), 32'd7);

        // ack timeout, queue retained in HALT, clr_err resumes
        stall_ack = 1;
        push_desc(8'd3, 3'd1, 1'b0, 16'h0AA0, cmd_of(8'd3, 3'd1, 1'b0, 16'h0AA0));
        push_desc(8'd2, 3'd2, 1'b0, 16'h0BB0, cmd_of(8'd2, 3'd2, 1'b0, 16'h0BB0));
        push_desc(8'd1, 3'd3, 1'b1, 16'h0CC0, cmd_of(8'd1, 3'd3, 1'b1, 16'h0CC0));
        desc_valid = 1'b0;
        wait_timeout(AT + 50);
        check("t4_ack_timeout_cyc", cyc - last_issue_cyc, AT);
        check("t4_cmd_zero", Command0, 32'h0);
        push_desc(8'd4, 3'd4, 1'b0, 16'h0DD0, cmd_of(8'd4, 3'd4, 1'b0, 16'h0DD0));
        desc_valid = 1'b0;
        repeat (5) @(negedge ACLK);
        check("t4_halt_cmd", Command0, 32'h0);
        check("t4_halt_err", 32'(timeout_err), 32'h1);
        check("t4_halt_busy", 32'(busy), 32'h1);
        check("t4_halt_queued", exp_cmd_q.size(), 3);
        stall_ack = 0;
        clr_err = 1'b1;
        @(negedge ACLK);
        clr_err = 1'b0;
        check("t4_err_cleared", 32'(timeout_err), 32'h0);
        wait_drain("t4");
        check("t4_count_abs", 32'(xfer_count), 32'd10);

        // completion timeout in BUSY
        never_raise = 1;
        push_desc(8'd1, 3'd0, 1'b0, 16'h0EE0, cmd_of(8'd1, 3'd0, 1'b0, 16'h0EE0));
        desc_valid = 1'b0;
        wait_timeout(XT + 100);
        check("t4b_busy_timeout_cyc", cyc - last_drop_cyc, XT + 1);
        check("t4b_cmd_zero", Command0, 32'h0);
        never_raise = 0;
        clr_err = 1'b1;
        @(negedge ACLK);
        clr_err = 1'b0;
        wait_drain("t4b");

        // illegal opcodes: handshake completes, nothing issued
        push_desc(8'h05, 3'd1, 1'b0, 16'h1234, 32'h0);
        push_desc(8'h00, 3'd1, 1'b0, 16'h1234, 32'h0);
        push_desc(8'hFF, 3'd1, 1'b0, 16'h1234, 32'h0);
        desc_valid = 1'b0;
        @(negedge ACLK);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_cmd", Command0, 32'h0);
        wait_drain("t5");

        // randomized traffic with random streamer timing and noise on unrelated bits
        noise = 1; rand_timing = 1;
        for (int i = 0; i < 40; i++) begin
            logic [7:0]  op;
            logic [2:0]  p;
            logic        a;
            logic [15:0] ad;
            if ($urandom_range(0, 9) < 8) op = 8'($urandom_range(1, 4));
            else if ($urandom_range(0, 1) == 0) op = 8'h00;
            else op = 8'($urandom_range(5, 255));
            p  = 3'($urandom);
            a  = 1'($urandom);
            ad = 16'($urandom);
            push_desc(op, p, a, ad, cmd_of(op, p, a, ad));
            desc_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge ACLK);
        end
        wait_drain("rand");
        noise = 0; rand_timing = 0;

        // asynchronous reset mid-BUSY with two descriptors queued
        never_raise = 1;
        push_desc(8'd1, 3'd1, 1'b0, 16'h5000, cmd_of(8'd1, 3'd1, 1'b0, 16'h5000));
        push_desc(8'd2, 3'd2, 1'b0, 16'h5001, cmd_of(8'd2, 3'd2, 1'b0, 16'h5001));
        push_desc(8'd3, 3'd3, 1'b0, 16'h5002, cmd_of(8'd3, 3'd3, 1'b0, 16'h5002));
        desc_valid = 1'b0;
        repeat (6) @(negedge ACLK);
        check("t6_pre_busy", 32'(busy), 32'h1);
        #2 ARESETN = 1'b0;
        #1;
        check("t6_async_cmd", Command0, 32'h0);
        check("t6_async_busy", 32'(busy), 32'h0);
        check("t6_async_count", 32'(xfer_count), 32'h0);
        exp_cmd_q.delete();
        exp_ill_q.delete();
        never_raise = 0;
        repeat (2) @(negedge ACLK);
        #2 ARESETN = 1'b1;
        @(negedge ACLK);
        check("t6_ready", 32'(desc_ready), 32'h1);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_cmd", Command0, 32'h0);
        push_desc(8'd2, 3'd5, 1'b1, 16'h6000, cmd_of(8'd2, 3'd5, 1'b1, 16'h6000));
        desc_valid = 1'b0;
        wait_drain("t6");
        check("t6_count_abs", 32'(xfer_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_cmd_sequencer.md
Name: stream_cmd_sequencer

Overview:
Autonomous command master for the streamer block's control interface. It drives Command0 and monitors Status0, so hardware (for example an on-chip scheduler) can run queued DMA transfers without host register pokes. Transfer descriptors enter a small FIFO and are issued one at a time. Each transfer follows the full protocol: issue command, wait for done to drop, wait for done to rise, then release the command to 0. The block sits beside the streamer on the same clock.

Parameters:
FIFO_DEPTH, 4, descriptor queue depth (power of 2, >=2)
ACK_TIMEOUT, 64, max cycles in ISSUE waiting for the done bit to fall
XFER_TIMEOUT, 65535, max cycles in BUSY waiting for the done bit to rise
RELEASE_CYCLES, 2, cycles Command0 is held at 0 after each transfer (>=1)

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset; asynchronous, active-low
desc_valid  in  1  descriptor offered
desc_ready  out  1  queue can accept (= !full)
desc_op  in  8  opcode: 1 write, 2 read, 3 write-all-banks, 4 read-all-banks
desc_proc  in  3  processor select
desc_all  in  1  broadcast-to-all-processors enable
desc_addr  in  16  start word address
Command0  out  32  command register to the streamer (registered)
Status0  in  32  streamer status; bit0 write-done, bit16 read-done
clr_err  in  1  clears timeout_err and leaves HALT
busy  out  1  state!=IDLE or queue non-empty
done_pulse  out  1  one-cycle pulse per completed transfer
illegal_pulse  out  1  one-cycle pulse when an illegal opcode is accepted
timeout_err  out  1  sticky timeout flag
xfer_count  out  16  completed-transfer counter

Behaviour:
- Reset (asynchronous, active-low) clears all state: Command0=0, FIFO empty, state=IDLE, done_pulse=0, illegal_pulse=0, timeout_err=0, xfer_count=0, desc_ready=1. Reset mid-transfer aborts the transfer and drops the queue.
- Push happens when desc_valid && desc_ready.
  - Opcodes outside 1..4: the handshake completes, but the descriptor is not queued; illegal_pulse=1 on the next cycle.
  - A push and a pop in the same cycle are legal. desc_ready depends only on full.
- Command word: {op[7:0], 1'b0, proc[2:0], 3'b0, all, addr[15:0]}.
- Done bit: Status0[0] for op 1/3; Status0[16] for op 2/4, latched with the descriptor.
- IDLE: Command0=0. If the FIFO is non-empty, pop it, register the command word into Command0 (visible the next cycle), clear the timer, go to ISSUE.
- ISSUE: hold Command0.
  - Done bit==0 -> BUSY, timer cleared.
  - Else, when the timer reaches ACK_TIMEOUT-1 -> set timeout_err, Command0<=0, go to HALT.
- BUSY: hold Command0.
  - Done bit==1 -> Command0<=0, done_pulse=1 for one cycle, xfer_count+1 (wraps 0xFFFF->0), go to RELEASE.
  - Timer reaching XFER_TIMEOUT-1 -> timeout_err=1, Command0<=0, go to HALT.
- RELEASE: Command0=0 for exactly RELEASE_CYCLES cycles, then IDLE. The next command therefore never appears earlier than RELEASE_CYCLES+1 cycles after done is seen.
- HALT: Command0=0. The queue is retained and pushes are still accepted. clr_err=1 clears timeout_err and goes to IDLE on the next cycle. clr_err in any other state only clears the flag.
- Status0 is sampled synchronously; the block shares ACLK with the streamer, so there is no CDC. Status0 bits other than 0 and 16 are ignored.
- Timers saturate; they do not wrap.

Test Plan:
1. Push op=1, proc=2, all=0, addr=0x0100. The status model drops bit0 1 cycle after the command and raises it 10 cycles later.
   -> Command0=0x01200100 the cycle after the push; done_pulse once; Command0=0 for 2 cycles; xfer_count=1; busy falls.
2. Push op=4, proc=0, all=1, addr=0x0000, with bit16 toggling.
   -> Command0=0x04010000; completion is keyed on bit16 only; bit0 activity is ignored.
3. With the status model stalled, push 5 descriptors back-to-back.
   -> The first is popped into ISSUE, then 4 queue; desc_ready=0 on the 6th attempt.
   -> When released, the commands are issued in FIFO order, each separated by a 0 gap of >=2 cycles; xfer_count=5.
4. Status never drops its done bit.
   -> 64 cycles after issue: timeout_err=1, Command0=0, HALT, and the queue is preserved.
   -> Pulse clr_err -> the next descriptor is issued.
5. Push op=0x05.
   -> illegal_pulse=1; no Command0 change; busy stays 0.
6. Assert ARESETN low mid-BUSY with 2 descriptors queued.
   -> Command0=0 immediately (asynchronously); after release: FIFO empty, xfer_count=0, state IDLE.
